data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Responder (memory side) of the core's data-memory request interface: accepts load/store
//  requests from the MEM stage, services them from an internal word RAM after a fixed
//  configurable latency, and returns load data with a one-cycle valid pulse. Replaces the
//  ideal zero-latency memory so the pipeline's stall/valid handling is exercised.
// PARAMETERS
//  DEPTH      1024   RAM size in 32-bit words
//  LATENCY    2      cycles from request cycle to response cycle, legal range >= 1
//  ADDR_BASE  0      byte address mapped to RAM word 0
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   asynchronous reset, active-high
//  enable      in   1   request strobe from core
//  cmd         in   1   0 = read (load), 1 = write (store)
//  addr        in   32  byte address
//  write_data  in   32  store data
//  mask        in   4   byte enables, mask[i] -> bits [8i+7:8i]
//  ready       out  1   responder can accept a request this cycle
//  valid       out  1   response strobe, high exactly one cycle per accepted request
//  load_data   out  32  read data, meaningful when valid is high
//  error       out  1   address out of range, meaningful only when valid is high (else 0)
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE, valid=0, error=0, load_data=0, counter=0, ready forced 0
//    while rst is high. RAM contents are not reset. An in-flight read is dropped (no valid).
//    A write already committed at acceptance survives reset.
//  - Accept = enable && ready at a rising edge; cmd/addr/write_data/mask latched then.
//    enable while ready=0 is ignored (no queue); the initiator holds the request until accepted.
//  - Word index = (addr - ADDR_BASE) >> 2, 32-bit unsigned; addr[1:0] ignored.
//    Out of range when index >= DEPTH (including wrap below ADDR_BASE).
//  - FSM: IDLE (ready=1) -> on accept: RESP if LATENCY==1, else WAIT with cnt=LATENCY-1.
//    WAIT (ready=0): cnt decrements each edge; cnt==1 -> RESP.
//    RESP (valid=1, ready=1): on accept, same transitions as from IDLE; no accept -> IDLE.
//  - Timing: request presented in cycle c -> valid high in cycle c+LATENCY. Back-to-back
//    requests accepted in RESP cycles give one response every LATENCY cycles; with
//    LATENCY=1 a response in every cycle.
//  - Write: committed to RAM at the acceptance edge, bytes with mask[i]=1 only. mask=0 is a
//    legal no-op write. Response has load_data=0.
//  - Read: full word regardless of mask. Captured into load_data at the edge entering RESP,
//    so a write accepted earlier is always visible. load_data holds its value outside RESP
//    until the next response.
//  - Error: out-of-range write leaves RAM unchanged; out-of-range read returns load_data=0.
//    Both responses have valid=1, error=1.
//  - rst asserted in WAIT or RESP -> IDLE immediately. After release, ready=1 at once and
//    no stale valid is issued.
// TESTING
//  1. LATENCY=2: write 0x10 <= 0xDEADBEEF mask 4'b1111 in cycle 0, then read 0x10
//     -> valid in cycle 2 (load_data=0, error=0), valid again 2 cycles after the read is
//     accepted with load_data=0xDEADBEEF, error=0.
//  2. Write 0x000000AA mask 4'b0001 to 0x10 (holding 0xDEADBEEF), read 0x10
//     -> load_data=0xDEADBEAA; a following write with mask 4'b0000 leaves 0xDEADBEAA.
//  3. LATENCY=1: enable held for 4 reads of 0x0,0x4,0x8,0xC -> valid high 4 consecutive
//     cycles, data in request order. LATENCY=3: enable held -> valid every 3rd cycle, ready
//     low 2 of every 3 cycles.
//  4. Read addr = ADDR_BASE + DEPTH*4 -> valid, error=1, load_data=0. Write there, then
//     re-read word DEPTH-1 -> unchanged.
//  5. Pulse enable during WAIT with a different addr -> ignored, exactly one valid for the
//     original request.
//  6. rst pulsed mid-WAIT of a read -> valid=0, ready=0 while rst=1; ready=1 after release;
//     no valid until a new request.

Source files
------------

// File: rtl/data_mem_if.sv
// Data-memory request/response bus between the core MEM stage (master) and a memory responder (slave).
interface data_mem_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = DW / 8;

  logic          enable;
  logic          cmd;
  logic [AW-1:0] addr;
  logic [DW-1:0] write_data;
  logic [MW-1:0] mask;
  logic          ready;
  logic          valid;
  logic [DW-1:0] load_data;
  logic          error;

  modport master (
    output enable, cmd, addr, write_data, mask,
    input  ready, valid, load_data, error
  );

  modport slave (
    input  enable, cmd, addr, write_data, mask,
    output ready, valid, load_data, error
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word RAM behind the data-memory bus: fixed-latency load/store responses with byte-masked
// stores and an out-of-range error flag.
module data_mem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] ADDR_BASE = 32'h0
) (
  input  logic       clk,
  input  logic       rst,
  data_mem_if.slave  bus
);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [31:0]   mem [DEPTH];

  logic [31:0]   offset, word;
  logic [IW-1:0] cur_idx, lat_idx, rsp_idx;
  logic          cur_ok, lat_ok, rsp_ok;
  logic          lat_rd, rsp_rd;
  logic          accept;
  logic [31:0]   load_data_q;
  logic          error_q;

  // Address decode of the request currently on the bus
  assign offset  = bus.addr - ADDR_BASE;
  assign word    = offset >> 2;
  assign cur_ok  = word < 32'(DEPTH);
  assign cur_idx = IW'(word);

  assign bus.ready     = !rst && (state != ST_WAIT);
  assign bus.valid     = (state == ST_RESP);
  assign bus.load_data = load_data_q;
  assign bus.error     = error_q;
  assign accept        = bus.enable && bus.ready;

  // With LATENCY==1 the response is produced at the acceptance edge, so take the live request
  assign rsp_rd  = accept ? !bus.cmd : lat_rd;
  assign rsp_ok  = accept ? cur_ok   : lat_ok;
  assign rsp_idx = accept ? cur_idx  : lat_idx;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nx = ST_RESP;
          end else begin
            state_nx = ST_WAIT;
            cnt_nx   = CW'(LATENCY - 1);
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_nx = cnt - CW'(1);
        if (cnt == CW'(1)) state_nx = ST_RESP;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      lat_rd      <= 1'b0;
      lat_ok      <= 1'b0;
      lat_idx     <= '0;
      load_data_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        lat_rd  <= !bus.cmd;
        lat_ok  <= cur_ok;
        lat_idx <= cur_idx;
      end
      // Read data sampled on entry to RESP so earlier stores are always visible
      if (state_nx == ST_RESP) begin
        load_data_q <= (rsp_rd && rsp_ok) ? mem[rsp_idx] : 32'h0;
      end
      error_q <= (state_nx == ST_RESP) && !rsp_ok;
    end
  end

  // Stores commit at acceptance; RAM contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (accept && bus.cmd && cur_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.mask[i]) mem[cur_idx][8*i +: 8] <= bus.write_data[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: three instances (latency 1/2/3), directed stimulus,
// expected responses queued at acceptance and checked by a monitor on every valid.
module tb_data_mem_responder;
  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_if b1();
  data_mem_if b2();
  data_mem_if b3();

  data_mem_responder #(.DEPTH(64),   .LATENCY(1), .ADDR_BASE(32'h0))   u1 (.clk(clk), .rst(rst), .bus(b1));
  data_mem_responder #(.DEPTH(1024), .LATENCY(2), .ADDR_BASE(32'h0))   u2 (.clk(clk), .rst(rst), .bus(b2));
  data_mem_responder #(.DEPTH(16),   .LATENCY(3), .ADDR_BASE(32'h100)) u3 (.clk(clk), .rst(rst), .bus(b3));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic drive(input int d, input logic en, input logic c, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] m);
    case (d)
      1: begin b1.enable = en; b1.cmd = c; b1.addr = a; b1.write_data = wd; b1.mask = m; end
      2: begin b2.enable = en; b2.cmd = c; b2.addr = a; b2.write_data = wd; b2.mask = m; end
      default: begin b3.enable = en; b3.cmd = c; b3.addr = a; b3.write_data = wd; b3.mask = m; end
    endcase
  endtask

  task automatic idle(input int d);
    drive(d, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  function automatic logic get_ready(input int d);
    case (d)
      1: return b1.ready;
      2: return b2.ready;
      default: return b3.ready;
    endcase
  endfunction

  task automatic get_out(input int d, output logic v, output logic e, output logic [31:0] ld);
    case (d)
      1: begin v = b1.valid; e = b1.error; ld = b1.load_data; end
      2: begin v = b2.valid; e = b2.error; ld = b2.load_data; end
      default: begin v = b3.valid; e = b3.error; ld = b3.load_data; end
    endcase
  endtask

  task automatic push(input int d, input exp_t e);
    case (d)
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  function automatic int q_size(input int d);
    case (d)
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic exp_t pop(input int d);
    case (d)
      1: return q1.pop_front();
      2: return q2.pop_front();
      default: return q3.pop_front();
    endcase
  endfunction

  // Called at a negedge; instance d has latency d. Returns at the negedge after acceptance.
  task automatic req(input int d, input logic c, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] m, input logic [31:0] xd, input logic xe,
                     input bit track, output int waits);
    exp_t e;
    waits = 0;
    drive(d, 1'b1, c, a, wd, m);
    while (!get_ready(d) && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!get_ready(d)) begin
      chk($sformatf("accept_timeout_d%0d", d), 32'(get_ready(d)), 32'd1);
      idle(d);
      return;
    end
    e.data = xd;
    e.err  = xe;
    e.cyc  = cyc + d;
    if (track) push(d, e);
    @(negedge clk);
  endtask

  task automatic wr(input int d, input logic [31:0] a, input logic [31:0] wd,
                    input logic [3:0] m, input logic xe);
    int w;
    req(d, 1'b1, a, wd, m, 32'h0, xe, 1'b1, w);
  endtask

  task automatic rd(input int d, input logic [31:0] a, input logic [31:0] xd,
                    input logic xe, output int w);
    req(d, 1'b0, a, 32'h0, 4'h0, xd, xe, 1'b1, w);
  endtask

  task automatic mon_one(input int d);
    logic v, e;
    logic [31:0] ld;
    exp_t x;
    get_out(d, v, e, ld);
    if (v) begin
      if (q_size(d) == 0) begin
        chk($sformatf("unexpected_valid_d%0d", d), 32'(v), 32'd0);
      end else begin
        x = pop(d);
        chk($sformatf("load_data_d%0d", d), ld, x.data);
        chk($sformatf("error_d%0d", d), 32'(e), 32'(x.err));
        chk($sformatf("resp_cycle_d%0d", d), 32'(cyc), 32'(x.cyc));
      end
    end else begin
      chk($sformatf("error_idle_d%0d", d), 32'(e), 32'd0);
    end
  endtask

  task automatic pulse_rst_in_wait(input int d, input logic c, input logic [31:0] a,
                                   input logic [31:0] wd);
    int w;
    logic v, e;
    logic [31:0] ld;
    req(d, c, a, wd, 4'hF, 32'h0, 1'b0, 1'b0, w);
    #2 rst = 1'b1;
    idle(d);
    #1;
    get_out(d, v, e, ld);
    chk("rst_ready", 32'(get_ready(d)), 32'd0);
    chk("rst_valid", 32'(v), 32'd0);
    @(negedge clk);
    get_out(d, v, e, ld);
    chk("rst_ready_hold", 32'(get_ready(d)), 32'd0);
    chk("rst_valid_hold", 32'(v), 32'd0);
    chk("rst_load_data", ld, 32'h0);
    rst = 1'b0;
    #1 chk("post_rst_ready", 32'(get_ready(d)), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic stim();
    int w;
    logic v, e;
    logic [31:0] ld;
    for (int d = 1; d <= 3; d++) idle(d);
    repeat (2) @(negedge clk);
    for (int d = 1; d <= 3; d++) begin
      get_out(d, v, e, ld);
      chk($sformatf("reset_ready_d%0d", d), 32'(get_ready(d)), 32'd0);
      chk($sformatf("reset_valid_d%0d", d), 32'(v), 32'd0);
      chk($sformatf("reset_load_data_d%0d", d), ld, 32'h0);
    end
    rst = 1'b0;
    #1;
    for (int d = 1; d <= 3; d++) chk($sformatf("release_ready_d%0d", d), 32'(get_ready(d)), 32'd1);
    @(negedge clk);

    // Full write then read, byte-masked write, no-op mask write
    wr(2, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    rd(2, 32'h10, 32'hDEADBEEF, 1'b0, w);
    chk("l2_wait", 32'(w), 32'd1);
    wr(2, 32'h10, 32'h000000AA, 4'b0001, 1'b0);
    rd(2, 32'h10, 32'hDEADBEAA, 1'b0, w);
    wr(2, 32'h10, 32'h12345678, 4'b0000, 1'b0);
    rd(2, 32'h10, 32'hDEADBEAA, 1'b0, w);

    // Out-of-range accesses must neither alias nor corrupt in-range words
    wr(2, 32'h0, 32'h0BADF00D, 4'hF, 1'b0);
    wr(2, 32'hFFC, 32'hCAFEF00D, 4'hF, 1'b0);
    rd(2, 32'h1000, 32'h0, 1'b1, w);
    wr(2, 32'h1000, 32'h11111111, 4'hF, 1'b1);
    rd(2, 32'hFFC, 32'hCAFEF00D, 1'b0, w);
    rd(2, 32'hFFE, 32'hCAFEF00D, 1'b0, w);
    rd(2, 32'h0, 32'h0BADF00D, 1'b0, w);
    rd(2, 32'hFFFFFFF0, 32'h0, 1'b1, w);

    // Enable pulsed during WAIT is ignored
    rd(2, 32'h10, 32'hDEADBEAA, 1'b0, w);
    drive(2, 1'b1, 1'b0, 32'h1000, 32'h0, 4'h0);
    @(negedge clk);
    idle(2);
    repeat (3) @(negedge clk);

    // Latency 1: back-to-back stream, one response per cycle
    for (int i = 0; i < 4; i++) wr(1, 32'(4 * i), 32'hA0000000 + 32'(i), 4'hF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rd(1, 32'(4 * i), 32'hA0000000 + 32'(i), 1'b0, w);
      chk($sformatf("l1_wait_%0d", i), 32'(w), 32'd0);
    end
    idle(1);

    // Latency 3 with nonzero base: ready low two of every three cycles
    wr(3, 32'h120, 32'h55AA55AA, 4'hF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      rd(3, 32'h120, 32'h55AA55AA, 1'b0, w);
      chk($sformatf("l3_wait_%0d", i), 32'(w), 32'd2);
    end
    rd(3, 32'h140, 32'h0, 1'b1, w);
    rd(3, 32'hFC, 32'h0, 1'b1, w);
    idle(3);
    repeat (4) @(negedge clk);

    // Reset in WAIT: committed write survives, in-flight read is dropped
    pulse_rst_in_wait(2, 1'b1, 32'h14, 32'h13572468);
    pulse_rst_in_wait(2, 1'b0, 32'h10, 32'h0);
    rd(2, 32'h14, 32'h13572468, 1'b0, w);
    rd(2, 32'h10, 32'hDEADBEAA, 1'b0, w);
    idle(2);

    repeat (8) @(negedge clk);
    for (int d = 1; d <= 3; d++) chk($sformatf("pending_d%0d", d), 32'(q_size(d)), 32'd0);
  endtask

  initial begin
    fork
      begin
        forever begin
          @(negedge clk);
          for (int d = 1; d <= 3; d++) mon_one(d);
        end
      end
      begin
        stim();
      end
    join_any
    disable fork;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
